// File: rtl/video_timing_gen_if.sv
// rtl/video_timing_gen_if.sv - raster timing bundle from the timing generator to the pixel stages
interface video_timing_gen_if #(
    parameter int CTR_WIDTH = 12
);
    logic                 hsync;
    logic                 vsync;
    logic                 de;
    logic [CTR_WIDTH-1:0] x;
    logic [CTR_WIDTH-1:0] y;
    logic                 frame_start;

    modport master (
        output hsync,
        output vsync,
        output de,
        output x,
        output y,
        output frame_start
    );

    modport slave (
        input hsync,
        input vsync,
        input de,
        input x,
        input y,
        input frame_start
    );
endinterface

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - raster timing generator advancing one pixel per pix_en strobe
module video_timing_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter bit HS_POL    = 1'b0,
    parameter bit VS_POL    = 1'b0,
    parameter int CTR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pix_en,
    video_timing_gen_if.master    vid
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    typedef logic [CTR_WIDTH-1:0] ctr_t;
    // One extra bit on the decode constants so a segment ending exactly at 2**CTR_WIDTH stays correct.
    typedef logic [CTR_WIDTH:0]   cmp_t;

    localparam ctr_t H_LAST     = ctr_t'(H_TOTAL - 1);
    localparam ctr_t V_LAST     = ctr_t'(V_TOTAL - 1);
    localparam cmp_t H_ACT_END  = cmp_t'(H_ACTIVE);
    localparam cmp_t V_ACT_END  = cmp_t'(V_ACTIVE);
    localparam cmp_t HS_BEGIN   = cmp_t'(H_ACTIVE + H_FP);
    localparam cmp_t HS_END     = cmp_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam cmp_t VS_BEGIN   = cmp_t'(V_ACTIVE + V_FP);
    localparam cmp_t VS_END     = cmp_t'(V_ACTIVE + V_FP + V_SYNC);

    if ((H_TOTAL - 1) >= (1 << CTR_WIDTH)) begin : g_h_range_err
        $error("video_timing_gen: H_TOTAL-1 (%0d) does not fit in CTR_WIDTH=%0d", H_TOTAL - 1, CTR_WIDTH);
    end
    if ((V_TOTAL - 1) >= (1 << CTR_WIDTH)) begin : g_v_range_err
        $error("video_timing_gen: V_TOTAL-1 (%0d) does not fit in CTR_WIDTH=%0d", V_TOTAL - 1, CTR_WIDTH);
    end

    ctr_t h_ctr;
    ctr_t v_ctr;
    cmp_t h_ext;
    cmp_t v_ext;
    logic h_last;
    logic v_last;
    logic de_next;
    logic hs_on;
    logic vs_on;
    logic origin;

    logic hsync_q;
    logic vsync_q;
    logic de_q;
    ctr_t x_q;
    ctr_t y_q;
    logic frame_start_q;

    assign h_ext  = {1'b0, h_ctr};
    assign v_ext  = {1'b0, v_ctr};
    assign h_last = (h_ctr == H_LAST);
    assign v_last = (v_ctr == V_LAST);

    // Decode of the pre-increment position; empty segments fall out as empty ranges.
    assign de_next = (h_ext < H_ACT_END) && (v_ext < V_ACT_END);
    assign hs_on   = (h_ext >= HS_BEGIN) && (h_ext < HS_END);
    assign vs_on   = (v_ext >= VS_BEGIN) && (v_ext < VS_END);
    assign origin  = (h_ctr == '0) && (v_ctr == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_ctr <= '0;
            v_ctr <= '0;
        end else if (pix_en) begin
            if (h_last) begin
                h_ctr <= '0;
                v_ctr <= v_last ? '0 : v_ctr + 1'b1;
            end else begin
                h_ctr <= h_ctr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync_q <= ~HS_POL;
            vsync_q <= ~VS_POL;
            de_q    <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
        end else if (pix_en) begin
            hsync_q <= hs_on ? HS_POL : ~HS_POL;
            vsync_q <= vs_on ? VS_POL : ~VS_POL;
            de_q    <= de_next;
            x_q     <= h_ctr;
            y_q     <= v_ctr;
        end
    end

    // Cleared on idle cycles so the pulse is one clk wide at any strobe rate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= pix_en && origin;
        end
    end

    assign vid.hsync       = hsync_q;
    assign vid.vsync       = vsync_q;
    assign vid.de          = de_q;
    assign vid.x           = x_q;
    assign vid.y           = y_q;
    assign vid.frame_start = frame_start_q;
endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - self-checking bench: default, small and degenerate timings side by side
module tb_video_timing_gen;
    localparam int W = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pix_en = 1'b0;

    always #5 clk = ~clk;

    video_timing_gen_if #(.CTR_WIDTH(W)) d_if ();
    video_timing_gen_if #(.CTR_WIDTH(W)) s_if ();
    video_timing_gen_if #(.CTR_WIDTH(W)) m_if ();

    video_timing_gen u_def (.clk(clk), .rst(rst), .pix_en(pix_en), .vid(d_if));

    video_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .CTR_WIDTH(W)
    ) u_small (.clk(clk), .rst(rst), .pix_en(pix_en), .vid(s_if));

    video_timing_gen #(
        .H_ACTIVE(8), .H_FP(0), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(0),
        .HS_POL(1'b0), .VS_POL(1'b0), .CTR_WIDTH(W)
    ) u_mid (.clk(clk), .rst(rst), .pix_en(pix_en), .vid(m_if));

    typedef struct packed {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic de;
        logic hs;
        logic vs;
        logic fs;
    } vout_t;

    typedef struct {
        int ha, hf, hsw, hb;
        int va, vf, vsw, vb;
        bit hp, vp;
    } tim_t;

    typedef struct {
        logic  r;
        logic  en;
        vout_t e;
    } vec_t;

    tim_t  cfg [3];
    int    pos [3];
    vout_t expv[3];
    string nm  [3];

    int n_checks = 0;
    int n_fail   = 0;

    function automatic vout_t mk(int x, int y, bit de, bit hs, bit vs, bit fs);
        vout_t v;
        v.x = W'(x); v.y = W'(y); v.de = de; v.hs = hs; v.vs = vs; v.fs = fs;
        return v;
    endfunction

    function automatic int frame_len(tim_t c);
        return (c.ha + c.hf + c.hsw + c.hb) * (c.va + c.vf + c.vsw + c.vb);
    endfunction

    // Position in the frame as a flat pixel index; h/v come from division, not from counters.
    function automatic vout_t model_pix(tim_t c, int p);
        int ht, h, v;
        ht = c.ha + c.hf + c.hsw + c.hb;
        h  = p % ht;
        v  = p / ht;
        return mk(h, v, (h < c.ha) && (v < c.va),
                  ((h >= c.ha + c.hf) && (h < c.ha + c.hf + c.hsw)) ? c.hp : !c.hp,
                  ((v >= c.va + c.vf) && (v < c.va + c.vf + c.vsw)) ? c.vp : !c.vp,
                  p == 0);
    endfunction

    function automatic vout_t dut_out(int k);
        case (k)
            0:       return {d_if.x, d_if.y, d_if.de, d_if.hsync, d_if.vsync, d_if.frame_start};
            1:       return {s_if.x, s_if.y, s_if.de, s_if.hsync, s_if.vsync, s_if.frame_start};
            default: return {m_if.x, m_if.y, m_if.de, m_if.hsync, m_if.vsync, m_if.frame_start};
        endcase
    endfunction

    task automatic check_vec(input string name, input vout_t got, input vout_t req);
        n_checks++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got x=%0d y=%0d de=%b hs=%b vs=%b fs=%b required x=%0d y=%0d de=%b hs=%b vs=%b fs=%b t=%0t",
                     name, got.x, got.y, got.de, got.hs, got.vs, got.fs,
                     req.x, req.y, req.de, req.hs, req.vs, req.fs, $time);
        end
    endtask

    task automatic check_int(input string name, input int got, input int req);
        n_checks++;
        if (got != req) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, got, req);
        end
    endtask

    // Drive inputs for the next rising edge, advance the model, then compare on the falling edge.
    task automatic cycle(input logic r, input logic en);
        rst    = r;
        pix_en = en;
        for (int k = 0; k < 3; k++) begin
            if (r) begin
                expv[k] = mk(0, 0, 1'b0, !cfg[k].hp, !cfg[k].vp, 1'b0);
                pos[k]  = 0;
            end else if (en) begin
                expv[k] = model_pix(cfg[k], pos[k]);
                pos[k]  = (pos[k] + 1) % frame_len(cfg[k]);
            end else begin
                expv[k].fs = 1'b0;
            end
        end
        @(negedge clk);
        for (int k = 0; k < 3; k++) check_vec(nm[k], dut_out(k), expv[k]);
    endtask

    vec_t tbl[12];

    initial begin
        int de_n, hs_n, hs_xmin, hs_xmax, fs_n, vs_n, vs_ymin, vs_ymax, de_ymax;
        int fs_first, fs_second, bad;
        vout_t snap, prev, cur;

        cfg[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
        cfg[1] = '{4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1};
        cfg[2] = '{8, 0, 3, 2, 6, 1, 2, 0, 1'b0, 1'b0};
        nm[0] = "model_default";
        nm[1] = "model_small";
        nm[2] = "model_degenerate";
        for (int k = 0; k < 3; k++) begin
            pos[k]  = 0;
            expv[k] = mk(0, 0, 1'b0, !cfg[k].hp, !cfg[k].vp, 1'b0);
        end

        // Small timing (active-high syncs), first line from reset, including hold cycles.
        tbl[0]  = '{1'b1, 1'b1, mk(0, 0, 0, 0, 0, 0)};
        tbl[1]  = '{1'b0, 1'b1, mk(0, 0, 1, 0, 0, 1)};
        tbl[2]  = '{1'b0, 1'b0, mk(0, 0, 1, 0, 0, 0)};
        tbl[3]  = '{1'b0, 1'b1, mk(1, 0, 1, 0, 0, 0)};
        tbl[4]  = '{1'b0, 1'b1, mk(2, 0, 1, 0, 0, 0)};
        tbl[5]  = '{1'b0, 1'b1, mk(3, 0, 1, 0, 0, 0)};
        tbl[6]  = '{1'b0, 1'b1, mk(4, 0, 0, 0, 0, 0)};
        tbl[7]  = '{1'b0, 1'b1, mk(5, 0, 0, 1, 0, 0)};
        tbl[8]  = '{1'b0, 1'b1, mk(6, 0, 0, 1, 0, 0)};
        tbl[9]  = '{1'b0, 1'b1, mk(7, 0, 0, 0, 0, 0)};
        tbl[10] = '{1'b0, 1'b1, mk(0, 1, 1, 0, 0, 0)};
        tbl[11] = '{1'b0, 1'b0, mk(0, 1, 1, 0, 0, 0)};
        for (int i = 0; i < 12; i++) begin
            cycle(tbl[i].r, tbl[i].en);
            check_vec($sformatf("table_%0d", i), dut_out(1), tbl[i].e);
        end

        // Default timing, one full-rate line.
        cycle(1'b1, 1'b1);
        de_n = 0; hs_n = 0; hs_xmin = 99999; hs_xmax = -1; fs_n = 0;
        for (int i = 0; i < 800; i++) begin
            cycle(1'b0, 1'b1);
            if (d_if.de) de_n++;
            if (d_if.frame_start) fs_n++;
            if (!d_if.hsync) begin
                hs_n++;
                if (int'(d_if.x) < hs_xmin) hs_xmin = int'(d_if.x);
                if (int'(d_if.x) > hs_xmax) hs_xmax = int'(d_if.x);
            end
        end
        check_int("line_de_count", de_n, 640);
        check_int("line_hsync_count", hs_n, 96);
        check_int("line_hsync_first_x", hs_xmin, 656);
        check_int("line_hsync_last_x", hs_xmax, 751);
        check_int("line_frame_start_count", fs_n, 1);

        // Reset mid-frame with pix_en held high, then the first enabled cycle is the origin.
        for (int i = 0; i < 200; i++) cycle(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b1);
            check_vec("in_reset", dut_out(0), mk(0, 0, 0, 1, 1, 0));
        end
        cycle(1'b0, 1'b1);
        check_vec("after_reset_origin", dut_out(0), mk(0, 0, 1, 1, 1, 1));

        // Degenerate timing (no H front porch, no V back porch): frame structure at full rate.
        cycle(1'b1, 1'b1);
        vs_n = 0; vs_ymin = 99999; vs_ymax = -1; de_ymax = -1; fs_first = -1; fs_second = -1;
        for (int i = 0; i < 234; i++) begin
            cycle(1'b0, 1'b1);
            if (m_if.frame_start) begin
                if (fs_first < 0) fs_first = i;
                else if (fs_second < 0) fs_second = i;
            end
            if (i < 117) begin
                if (!m_if.vsync) begin
                    vs_n++;
                    if (int'(m_if.y) < vs_ymin) vs_ymin = int'(m_if.y);
                    if (int'(m_if.y) > vs_ymax) vs_ymax = int'(m_if.y);
                end
                if (m_if.de && int'(m_if.y) > de_ymax) de_ymax = int'(m_if.y);
            end
        end
        check_int("frame_vsync_pixels", vs_n, 26);
        check_int("frame_vsync_first_y", vs_ymin, 7);
        check_int("frame_vsync_last_y", vs_ymax, 8);
        check_int("frame_de_last_y", de_ymax, 5);
        check_int("frame_start_first", fs_first, 0);
        check_int("frame_start_period", fs_second - fs_first, 117);

        // Quarter-rate strobe: outputs move only on enabled cycles, pulse stays one clk.
        cycle(1'b1, 1'b0);
        fs_n = 0; fs_first = -1; fs_second = -1; bad = 0;
        prev = dut_out(2);
        for (int i = 0; i < 936; i++) begin
            cycle(1'b0, (i % 4) == 0);
            cur = dut_out(2);
            if (cur.fs) begin
                fs_n++;
                if (fs_first < 0) fs_first = i;
                else if (fs_second < 0) fs_second = i;
            end
            if ((i % 4) != 0 && cur[W*2+3:1] != prev[W*2+3:1]) bad++;
            prev = cur;
        end
        check_int("quarter_rate_fs_cycles", fs_n, 2);
        check_int("quarter_rate_fs_period", fs_second - fs_first, 468);
        check_int("quarter_rate_idle_changes", bad, 0);

        // Long pause mid-line on the default timing.
        cycle(1'b1, 1'b1);
        for (int i = 0; i < 300; i++) cycle(1'b0, 1'b1);
        snap = dut_out(0);
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            cycle(1'b0, 1'b0);
            if (dut_out(0) !== snap) bad++;
        end
        check_vec("pause_snapshot", snap, mk(299, 0, 1, 1, 1, 0));
        check_int("pause_changes", bad, 0);

        // Random strobe pattern with occasional resets, all three timings against the model.
        cycle(1'b1, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 499) == 0, $urandom_range(0, 3) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
